// File: rtl/nq_ucode_pkg.sv
// Shared definitions for the microcode sequencer and the control-word decoder:
// state encoding, opcodes, ROM entry layout and control-field placement.
package nq_ucode_pkg;

    localparam int CTRL_W = 33;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } seqState_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_BR   = 4'h4;
    localparam logic [3:0] OP_BAD  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ROM entry: {last, ctrl}; last ends the instruction after this word
    typedef struct packed {
        logic              last;
        logic [CTRL_W-1:0] ctrl;
    } romEntry_t;

    localparam int ALU_OP_LSB   = 0;
    localparam int ALU_SRCA_LSB = 5;
    localparam int ALU_SRCB_LSB = 7;
    localparam int REG_WE_BIT   = 9;
    localparam int REG_DST_LSB  = 10;
    localparam int REG_SRC_LSB  = 14;
    localparam int MEM_RD_BIT   = 18;
    localparam int MEM_WR_BIT   = 19;
    localparam int MEM_SIZE_LSB = 20;
    localparam int SETCC_LSB    = 22;
    localparam int PC_LD_BIT    = 25;
    localparam int PC_SRC_LSB   = 26;
    localparam int IMM_SEL_LSB  = 28;
    localparam int IR_LD_BIT    = 31;
    localparam int BRANCH_BIT   = 32;

    // Field view of a control word; bit positions agree with the offsets above
    typedef struct packed {
        logic       branch;
        logic       irLd;
        logic [2:0] immSel;
        logic [1:0] pcSrc;
        logic       pcLd;
        logic [2:0] setCc;
        logic [1:0] memSize;
        logic       memWr;
        logic       memRd;
        logic [3:0] regSrc;
        logic [3:0] regDst;
        logic       regWe;
        logic [1:0] aluSrcB;
        logic [1:0] aluSrcA;
        logic [4:0] aluOp;
    } ctrlFields_t;

    function automatic logic [CTRL_W-1:0] uop(
        input logic [4:0] aluOp,
        input logic       regWe,
        input logic       memRd,
        input logic       memWr,
        input logic [2:0] setCc,
        input logic       pcLd,
        input logic       branch
    );
        ctrlFields_t f;
        f        = '0;
        f.aluOp  = aluOp;
        f.regWe  = regWe;
        f.memRd  = memRd;
        f.memWr  = memWr;
        f.setCc  = setCc;
        f.pcLd   = pcLd;
        f.branch = branch;
        return f;
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Combinational microcode ROM indexed by {opcode, step}. Entries not listed
// below read as a NOP word with the last bit set.
module ucode_rom #(
    parameter int OP_W   = 4,
    parameter int STEP_W = 2,
    parameter int CTRL_W = 33
) (
    input  logic [OP_W+STEP_W-1:0] addr,
    output logic [CTRL_W:0]        data
);
    import nq_ucode_pkg::*;

    logic              lastBit;
    logic [CTRL_W-1:0] word;

    assign data = {lastBit, word};

    always_comb begin
        lastBit = 1'b1;
        word    = '0;
        case (addr)
            {OP_W'(OP_ADD), STEP_W'(0)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_ADD), STEP_W'(1)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_ADD), STEP_W'(2)}: begin lastBit = 1'b1; word = CTRL_W'(uop(5'd3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0)); end
            {OP_W'(OP_LD),  STEP_W'(0)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd4, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_LD),  STEP_W'(1)}: begin lastBit = 1'b1; word = CTRL_W'(uop(5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_ST),  STEP_W'(0)}: begin lastBit = 1'b1; word = CTRL_W'(uop(5'd5, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_BR),  STEP_W'(0)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd6, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0)); end
            {OP_W'(OP_BR),  STEP_W'(1)}: begin lastBit = 1'b1; word = CTRL_W'(uop(5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1)); end
            // Deliberately never sets last: exercises the run-off-the-end trap
            {OP_W'(OP_BAD), STEP_W'(0)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd7,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_BAD), STEP_W'(1)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd8,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_BAD), STEP_W'(2)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd9,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            {OP_W'(OP_BAD), STEP_W'(3)}: begin lastBit = 1'b0; word = CTRL_W'(uop(5'd10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0)); end
            default: ;
        endcase
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetches an instruction into IR, then plays its ROM
// micro-program one registered control word per cycle, honouring stall.
module ucode_sequencer #(
    parameter int OP_W   = 4,
    parameter int STEP_W = 2,
    parameter int CTRL_W = 33
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic [15:0]       fetch_data,
    input  logic              stall,
    output logic [CTRL_W-1:0] control_signals,
    output logic              ctrl_valid,
    output logic [15:0]       ir,
    output logic              halted,
    output logic              illegal
);
    import nq_ucode_pkg::*;

    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    seqState_t         state;
    logic [STEP_W-1:0] step;
    logic              reqEnable;
    logic [OP_W-1:0]   opcode;
    logic [CTRL_W:0]   romData;
    logic              romLast;
    logic [CTRL_W-1:0] romWord;
    logic              ackHalt;

    assign opcode             = ir[15 -: OP_W];
    assign {romLast, romWord} = romData;
    assign ackHalt            = (fetch_data[15 -: OP_W] == OP_W'(OP_HALT));

    // reqEnable keeps the request low for the cycle after a reset edge, so an
    // interrupted fetch visibly drops before it is re-issued
    assign fetch_req = (state == FETCH) && reqEnable;

    ucode_rom #(
        .OP_W  (OP_W),
        .STEP_W(STEP_W),
        .CTRL_W(CTRL_W)
    ) uRom (
        .addr({opcode, step}),
        .data(romData)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= FETCH;
            step            <= '0;
            reqEnable       <= 1'b0;
            ir              <= '0;
            control_signals <= '0;
            ctrl_valid      <= 1'b0;
            halted          <= 1'b0;
            illegal         <= 1'b0;
        end else begin
            reqEnable <= 1'b1;
            case (state)
                FETCH: begin
                    if (!stall) begin
                        control_signals <= '0;
                        ctrl_valid      <= 1'b0;
                    end
                    if (fetch_ack && reqEnable) begin
                        ir   <= fetch_data;
                        step <= '0;
                        if (ackHalt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        control_signals <= romWord;
                        ctrl_valid      <= 1'b1;
                        if (romLast) begin
                            state <= FETCH;
                        end else if (step == STEP_MAX) begin
                            illegal <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                HALT: begin
                    control_signals <= '0;
                    ctrl_valid      <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
